// File: rtl/ssd_pkg.sv
// Purpose : shared types and constants for the multiplexed seven-segment driver.
// Latency : n/a (package only).
// Backpressure: n/a. Contents: converter state encoding, segment constants, nibble decoder.
package ssd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_e;

    // Cathodes are active-low, bit order {a,b,c,d,e,f,g} with a at the MSB.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // 0-9 map to digit glyphs; 10-15 cannot occur in valid BCD and show blank.
    function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Purpose : sequential shift-add-3 binary-to-BCD converter with one-deep load hold and overflow flag.
// Latency : display register updates DATA_W+1 cycles after the load edge.
// Backpressure: none; a load while busy is held (latest wins) and started straight from COMMIT.
// Ports   : ClkPort/Reset (async, active-high), value_i/load_i in, busy_o, disp_o (BCD digits), disp_ovf_o.
module bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 16
) (
    input  logic                    ClkPort,
    input  logic                    Reset,
    input  logic [DATA_W-1:0]       value_i,
    input  logic                    load_i,
    output logic                    busy_o,
    output logic [NUM_DIGITS*4-1:0] disp_o,
    output logic                    disp_ovf_o
);

    localparam int WORK_W = NUM_DIGITS * 4;
    localparam int CNT_W  = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(DATA_W - 1);

    conv_state_e       state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [WORK_W-1:0] work_q, work_d;
    logic [WORK_W-1:0] adj;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              pend_q, pend_d;
    logic [WORK_W-1:0] disp_q, disp_d;
    logic              disp_ovf_q, disp_ovf_d;

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            work_q     <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            hold_q     <= '0;
            pend_q     <= 1'b0;
            disp_q     <= '0;
            disp_ovf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            work_q     <= work_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            pend_q     <= pend_d;
            disp_q     <= disp_d;
            disp_ovf_q <= disp_ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (load_i) state_d = ST_SHIFT;
            ST_SHIFT:  if (cnt_q == LAST_SHIFT) state_d = ST_COMMIT;
            ST_COMMIT: state_d = (pend_q || load_i) ? ST_SHIFT : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Add-3 correction applied to every nibble before the shift.
    always_comb begin
        adj = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            adj[i*4 +: 4] = (work_q[i*4 +: 4] >= 4'd5) ? work_q[i*4 +: 4] + 4'd3
                                                       : work_q[i*4 +: 4];
        end
    end

    always_comb begin
        shreg_d    = shreg_q;
        work_d     = work_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        pend_d     = pend_q;
        disp_d     = disp_q;
        disp_ovf_d = disp_ovf_q;

        // Any load outside IDLE (including the COMMIT cycle) is parked; latest value wins.
        if (state_q != ST_IDLE && load_i) begin
            hold_d = value_i;
            pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (load_i) begin
                    shreg_d = value_i;
                    work_d  = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                // The bit leaving the top nibble cannot be represented: sticky overflow.
                ovf_d   = ovf_q | adj[WORK_W-1];
                work_d  = {adj[WORK_W-2:0], shreg_q[DATA_W-1]};
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_COMMIT: begin
                disp_d     = work_q;
                disp_ovf_d = ovf_q;
                if (pend_q || load_i) begin
                    // A load in this very cycle is newer than anything in hold_q.
                    shreg_d = load_i ? value_i : hold_q;
                    work_d  = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign disp_o     = disp_q;
    assign disp_ovf_o = disp_ovf_q;

endmodule

// File: rtl/ssd_scan_driver.sv
// Purpose : multiplexed NUM_DIGITS seven-segment driver fed by a sequential BCD converter.
// Latency : display change reaches seg one edge after the display register updates.
// Backpressure: none; loads while busy are held in the converter, busy reports activity.
// Ports   : ClkPort, Reset (async, active-high), value/load in, busy, anode (active-low
//           one-hot, bit 0 rightmost), seg ({a..g} active-low), dp (always off).
// Option  : SSD_LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_W      = 16,
    parameter int REFRESH_DIV = 17
) (
    input  logic                  ClkPort,
    input  logic                  Reset,
    input  logic [DATA_W-1:0]     value,
    input  logic                  load,
    output logic                  busy,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [NUM_DIGITS*4-1:0]  disp;
    logic                     disp_ovf;

    logic [REFRESH_DIV-1:0]   rcnt_q, rcnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     started_q, started_d;
    logic [NUM_DIGITS-1:0]    anode_q, anode_d;
    logic [6:0]               seg_q, seg_d;
    logic                     tick;
    logic                     lead_blank;
    logic [3:0]               nib;

    bin2bcd_seq #(
        .NUM_DIGITS (NUM_DIGITS),
        .DATA_W     (DATA_W)
    ) u_conv (
        .ClkPort    (ClkPort),
        .Reset      (Reset),
        .value_i    (value),
        .load_i     (load),
        .busy_o     (busy),
        .disp_o     (disp),
        .disp_ovf_o (disp_ovf)
    );

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            rcnt_q    <= '0;
            idx_q     <= '0;
            started_q <= 1'b0;
            anode_q   <= '1;
            seg_q     <= SEG_BLANK;
        end else begin
            rcnt_q    <= rcnt_d;
            idx_q     <= idx_d;
            started_q <= started_d;
            anode_q   <= anode_d;
            seg_q     <= seg_d;
        end
    end

    assign tick   = &rcnt_q;
    assign rcnt_d = rcnt_q + REFRESH_DIV'(1);

    // The first tick after reset lights digit 0 rather than advancing past it.
    always_comb begin
        idx_d     = idx_q;
        started_d = started_q | tick;
        if (tick) begin
            if (!started_q || idx_q == LAST_IDX) idx_d = '0;
            else                                  idx_d = idx_q + IDX_W'(1);
        end
    end

    assign nib = disp[{idx_d, 2'b00} +: 4];

`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msd;

    // Highest nonzero digit; stays 0 for an all-zero display so digit 0 is always shown.
    always_comb begin
        msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (disp[i*4 +: 4] != 4'd0) msd = IDX_W'(i);
        end
    end

    assign lead_blank = (idx_d > msd);
`else
    assign lead_blank = 1'b0;
`endif

    // Outputs are built from the next index so anode and seg always move together.
    always_comb begin
        anode_d = '1;
        seg_d   = SEG_BLANK;
        if (started_d) begin
            anode_d[idx_d] = 1'b0;
            if (disp_ovf)        seg_d = SEG_DASH;
            else if (lead_blank) seg_d = SEG_BLANK;
            else                 seg_d = nibble_to_seg(nib);
        end
    end

    assign anode = anode_q;
    assign seg   = seg_q;
    assign dp    = 1'b1;

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Parametrised multiplexed seven-segment driver that replaces the fixed 4-digit counter path in the board top level. It accepts a binary value on a load strobe, converts it to BCD with a sequential shift-add-3 engine, and time-multiplexes NUM_DIGITS digits onto the shared cathode bus. Overflow is detected and displayed. Leading-zero blanking is optional.

## Interface
- NUM_DIGITS, 4: digits driven; legal range 1..8.
- DATA_W, 16: width of the binary input; legal range 4..32.
- REFRESH_DIV, 17: the digit slot advances every 2^REFRESH_DIV ClkPort cycles.
- ClkPort  input  1  system clock; all logic is on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- value  input  DATA_W  unsigned binary number to display.
- load  input  1  single-cycle strobe that samples value.
- busy  output  1  high while a conversion is in flight.
- anode  output  NUM_DIGITS  active-low one-hot digit enable; bit 0 is the rightmost digit.
- seg  output  7  active-low cathodes; the bit order is {a,b,c,d,e,f,g}, with a at the MSB.
- dp  output  1  decimal point; always 1 (off).

## Operation
- Converter FSM states:
  - IDLE: when load=1, capture value into the shift register, clear the BCD work register and the overflow flag, and go to SHIFT.
  - SHIFT: each cycle, add 3 to every work nibble ≥5, then shift {work, shreg} left by 1. This repeats for exactly DATA_W cycles, then the FSM goes to COMMIT.
  - COMMIT: copy the work register to the display register and latch the overflow flag. Return to IDLE, or go to SHIFT if a load is pending.
- The work register is NUM_DIGITS×4 bits. Any 1 shifted out of the top nibble sets a sticky overflow flag for that conversion.
- load while busy: capture value into a hold register and set pending. The most recent load wins. On COMMIT, the hold value starts a new conversion directly (COMMIT→SHIFT) and busy stays high.
- load in the same cycle as COMMIT counts as pending, so it is not lost.
- Scanner behaviour:
  - A REFRESH_DIV-bit free-running counter produces a tick on wrap.
  - On each tick, the digit index increments, wrapping from NUM_DIGITS-1 to 0.
  - anode drives a 0 on the indexed bit only.
  - seg encodes the indexed display nibble as 0–9. Nibble values 10–15 show blank (7'h7F).
- When the display overflow flag is set, every digit shows '-' (seg=7'b1111110).
- anode and seg are registered, so the display never shows partial conversion results.

## Timing
- Reset values:
  - anode = all 1
  - seg = 7'h7F
  - dp = 1
  - busy = 0
  - display register = 0, overflow flag = 0
  - digit index = 0, refresh counter = 0
  - FSM = IDLE, pending = 0
- Conversion timing, with load sampled at edge k:
  - busy=1 from k+1.
  - The display register updates at edge k+DATA_W+1.
  - busy=0 after edge k+DATA_W+1, unless a load is pending.
- Display timing:
  - After reset, the first tick arrives at cycle 2^REFRESH_DIV and selects digit 0.
  - Each digit is lit for 2^REFRESH_DIV cycles.
  - A change to the display register takes effect on the next ClkPort edge for the currently lit digit. The scanner phase is not reset.
- Reset mid-conversion aborts the conversion immediately. The display register returns to 0 and nothing is committed.

## Configuration
- SSD_LEADING_ZERO_BLANK_EN defined: each digit above the most significant nonzero display digit outputs seg=7'h7F while its anode is still scanned.
  - Digit 0 is always shown.
  - Overflow '-' overrides blanking.
- Not defined: all NUM_DIGITS digits are displayed, including leading zeros.

## Structure
- Package ssd_pkg holds:
  - the FSM state encoding (IDLE, SHIFT, COMMIT);
  - the 16-entry nibble-to-segment constant function;
  - the SEG_BLANK and SEG_DASH constants.
- Sub-module bin2bcd_seq contains the converter FSM, the hold/pending logic and overflow detection.
- The top module contains the refresh counter, digit index, blanking logic and output registers.

## Test plan
- Reset, then load value=1234 with NUM_DIGITS=4, DATA_W=16 → busy high for 17 cycles. Scanning digits 0..3 gives seg codes for 4, 3, 2, 1 with anode 1110, 1101, 1011, 0111.
- Load value=10000 with 4 digits → all four digits show 7'b1111110.
- Load 42, then load 77 three cycles later → 42 is committed first, then 77 after DATA_W+1 more cycles. busy stays high continuously, and 77 is the final display.
- With SSD_LEADING_ZERO_BLANK_EN, load 5 → digits 3..1 show 7'h7F and digit 0 shows the code for 5. Load 0 → digit 0 shows '0'.
- Assert Reset during SHIFT of 9999 → the display stays 0, busy=0 and anode=1111 until the first tick.
- REFRESH_DIV=2, NUM_DIGITS=8 → anode rotates every 4 cycles and wraps from 01111111 to 11111110.
